// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: immediate generation, control decode, load-use
// hazard detection with bubble insertion, and stall/flush handling.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              instr,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     load_use_stall,
  output logic                     valid_o,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [DATA_WIDTH-1:0]    Immediate,
  output logic [4:0]               rd_o,
  output logic [2:0]               funct3_o,
  output logic [OPCODE_LENGTH-1:0] alu_ctrl_o,
  output logic                     alu_src_o,
  output logic                     reg_write_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [15:0]              bubble_cnt
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_JALR   = 7'b1100111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [DATA_WIDTH-1:0]    imm;
    logic [4:0]               rd;
    logic [2:0]               funct3;
    logic [OPCODE_LENGTH-1:0] alu_ctrl;
    logic                     alu_src;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
  } ex_t;

  ex_t        ex_q, ex_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  opcode_e    opcode;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = opcode_e'(instr[6:0]);
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  logic [DATA_WIDTH-1:0]    dec_imm;
  logic [OPCODE_LENGTH-1:0] dec_alu_ctrl;
  logic dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
  logic uses_rs1, uses_rs2;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    dec_imm       = '0;
    dec_alu_ctrl  = '0;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_ctrl  = OPCODE_LENGTH'({instr[30], funct3});
      end
      OP_IMM: begin
        uses_rs1      = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
        // Shifts keep instr[30] to tell SRAI from SRLI.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec_alu_ctrl = OPCODE_LENGTH'({instr[30], funct3});
        else
          dec_alu_ctrl = OPCODE_LENGTH'({1'b0, funct3});
      end
      OP_LOAD: begin
        uses_rs1      = 1'b1;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
      end
      OP_JALR: begin
        uses_rs1      = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_imm  = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_imm       = {instr[31:12], {(DATA_WIDTH-20){1'b0}}};
      end
      OP_JAL: begin
        dec_reg_write = 1'b1;
        dec_imm       = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    // x0 is never written, which also keeps it out of hazard matching.
    if (rd == 5'd0) dec_reg_write = 1'b0;
  end

  assign load_use_stall = in_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                          ((uses_rs1 & (ex_q.rd == rs1)) | (uses_rs2 & (ex_q.rd == rs2)));

  // Priority below reset: flush, then stall, then load-use bubble, then load.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      if (load_use_stall) begin
        ex_d = '0;
        if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
      end else begin
        ex_d.valid     = in_valid;
        ex_d.src_a     = rs1_data;
        ex_d.src_b     = rs2_data;
        ex_d.imm       = dec_imm;
        ex_d.rd        = rd;
        ex_d.funct3    = funct3;
        ex_d.alu_ctrl  = dec_alu_ctrl;
        ex_d.alu_src   = dec_alu_src   & in_valid;
        ex_d.reg_write = dec_reg_write & in_valid;
        ex_d.mem_read  = dec_mem_read  & in_valid;
        ex_d.mem_write = dec_mem_write & in_valid;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_o     = ex_q.valid;
  assign SrcA        = ex_q.src_a;
  assign SrcB        = ex_q.src_b;
  assign Immediate   = ex_q.imm;
  assign rd_o        = ex_q.rd;
  assign funct3_o    = ex_q.funct3;
  assign alu_ctrl_o  = ex_q.alu_ctrl;
  assign alu_src_o   = ex_q.alu_src;
  assign reg_write_o = ex_q.reg_write;
  assign mem_read_o  = ex_q.mem_read;
  assign mem_write_o = ex_q.mem_write;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, immediates, load-use bubbles,
// stall/flush priority, reset and bubble counter saturation.
module tb_id_ex_stage;

  localparam logic [31:0] ADDI  = 32'hFFB00293; // addi x5,x0,-5
  localparam logic [31:0] SLTI  = 32'h0032A313; // slti x6,x5,3
  localparam logic [31:0] SLTI6 = 32'h00332313; // slti x6,x6,3
  localparam logic [31:0] LW5   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] LW0   = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] SUB   = 32'h405003B3; // sub x7,x0,x5
  localparam logic [31:0] SRAI  = 32'h4032D293; // srai x5,x5,3
  localparam logic [31:0] SW    = 32'hFE112E23; // sw x1,-4(x2)
  localparam logic [31:0] BEQ   = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] LUI   = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] JAL   = 32'h0080006F; // jal x0,8

  logic        clk, reset, in_valid, stall, flush;
  logic [31:0] instr, rs1_data, rs2_data;
  logic        load_use_stall, valid_o, alu_src_o, reg_write_o, mem_read_o, mem_write_o;
  logic [31:0] SrcA, SrcB, Immediate;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [3:0]  alu_ctrl_o;
  logic [15:0] bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt;

  id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .flush(flush),
    .load_use_stall(load_use_stall), .valid_o(valid_o), .SrcA(SrcA), .SrcB(SrcB),
    .Immediate(Immediate), .rd_o(rd_o), .funct3_o(funct3_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_src_o(alu_src_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr    = i;
    rs1_data = a;
    rs2_data = b;
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"},     32'(valid_o), 32'd0);
    check({tag, " SrcA"},      SrcA, 32'd0);
    check({tag, " SrcB"},      SrcB, 32'd0);
    check({tag, " Immediate"}, Immediate, 32'd0);
    check({tag, " rd"},        32'(rd_o), 32'd0);
    check({tag, " funct3"},    32'(funct3_o), 32'd0);
    check({tag, " alu_ctrl"},  32'(alu_ctrl_o), 32'd0);
    check({tag, " alu_src"},   32'(alu_src_o), 32'd0);
    check({tag, " reg_write"}, 32'(reg_write_o), 32'd0);
    check({tag, " mem_read"},  32'(mem_read_o), 32'd0);
    check({tag, " mem_write"}, 32'(mem_write_o), 32'd0);
    check({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'd0);
    check({tag, " load_use"},  32'(load_use_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    instr = ADDI; rs1_data = 32'hDEADBEEF; rs2_data = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");

    // I-type capture
    reset = 1'b0;
    drive(ADDI, 32'h0, 32'h0);
    tick();
    check("addi valid",     32'(valid_o), 32'd1);
    check("addi imm",       Immediate, 32'hFFFFFFFB);
    check("addi rd",        32'(rd_o), 32'd5);
    check("addi alu_src",   32'(alu_src_o), 32'd1);
    check("addi reg_write", 32'(reg_write_o), 32'd1);
    check("addi alu_ctrl",  32'(alu_ctrl_o), 32'd0);
    drive(SLTI, 32'hFFFFFFFB, 32'h12345678);
    check("slti no hazard", 32'(load_use_stall), 32'd0);
    tick();
    check("slti SrcA",     SrcA, 32'hFFFFFFFB);
    check("slti SrcB",     SrcB, 32'h12345678);
    check("slti imm",      Immediate, 32'h3);
    check("slti funct3",   32'(funct3_o), 32'd2);
    check("slti alu_ctrl", 32'(alu_ctrl_o), 32'd2);
    check("slti rd",       32'(rd_o), 32'd6);

    // Load-use on rs1
    drive(LW5, 32'h100, 32'h0);
    check("lw no hazard", 32'(load_use_stall), 32'd0);
    tick();
    check("lw mem_read",  32'(mem_read_o), 32'd1);
    check("lw reg_write", 32'(reg_write_o), 32'd1);
    check("lw alu_ctrl",  32'(alu_ctrl_o), 32'd0);
    drive(SLTI, 32'h0, 32'h0);
    check("rs1 hazard", 32'(load_use_stall), 32'd1);
    tick();
    check("bubble valid",    32'(valid_o), 32'd0);
    check("bubble mem_read", 32'(mem_read_o), 32'd0);
    check("bubble rd",       32'(rd_o), 32'd0);
    check("bubble cnt 1",    32'(bubble_cnt), 32'd1);
    check("hazard dropped",  32'(load_use_stall), 32'd0);
    tick();
    check("dep loaded valid", 32'(valid_o), 32'd1);
    check("dep loaded rd",    32'(rd_o), 32'd6);

    // Independent consumer
    drive(LW5, 32'h0, 32'h0);
    tick();
    drive(SLTI6, 32'h0, 32'h0);
    check("indep no hazard", 32'(load_use_stall), 32'd0);
    tick();
    check("indep valid", 32'(valid_o), 32'd1);
    check("indep cnt",   32'(bubble_cnt), 32'd1);

    // Load-use on rs2, then R-type decode
    drive(LW5, 32'h0, 32'h0);
    tick();
    drive(SUB, 32'h0, 32'h0);
    check("rs2 hazard", 32'(load_use_stall), 32'd1);
    tick();
    check("rs2 bubble cnt", 32'(bubble_cnt), 32'd2);
    tick();
    check("sub rd",       32'(rd_o), 32'd7);
    check("sub alu_ctrl", 32'(alu_ctrl_o), 32'd8);
    check("sub alu_src",  32'(alu_src_o), 32'd0);

    // Load into x0 never causes a hazard
    drive(LW0, 32'h0, 32'h0);
    tick();
    check("lw x0 reg_write", 32'(reg_write_o), 32'd0);
    check("lw x0 mem_read",  32'(mem_read_o), 32'd1);
    drive(ADDI, 32'h0, 32'h0);
    check("x0 no hazard", 32'(load_use_stall), 32'd0);
    tick();
    drive(SRAI, 32'h0, 32'h0);
    tick();
    check("srai alu_ctrl", 32'(alu_ctrl_o), 32'hD);
    check("srai alu_src",  32'(alu_src_o), 32'd1);

    // Flush beats stall
    stall = 1'b1; flush = 1'b1;
    drive(LW5, 32'h0, 32'h0);
    tick();
    check("flush+stall valid", 32'(valid_o), 32'd0);
    check("flush+stall imm",   Immediate, 32'd0);
    stall = 1'b0; flush = 1'b0;
    drive(ADDI, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    drive(LUI, 32'h55555555, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall hold imm",   Immediate, 32'hFFFFFFFB);
      check("stall hold valid", 32'(valid_o), 32'd1);
      check("stall hold SrcA",  SrcA, 32'd0);
    end
    stall = 1'b0;

    // Stall during a hazard holds the load and keeps the hazard up
    drive(LW5, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    drive(SLTI, 32'h0, 32'h0);
    tick();
    check("stall hazard mem_read", 32'(mem_read_o), 32'd1);
    check("stall hazard held",     32'(load_use_stall), 32'd1);
    check("stall hazard cnt",      32'(bubble_cnt), 32'd2);
    stall = 1'b0;
    #1;
    tick();
    check("post-stall bubble cnt", 32'(bubble_cnt), 32'd3);
    check("post-stall valid",      32'(valid_o), 32'd0);
    tick();

    // Flush during a hazard is not counted
    drive(LW5, 32'h0, 32'h0);
    tick();
    flush = 1'b1;
    drive(SLTI, 32'h0, 32'h0);
    tick();
    flush = 1'b0;
    #1;
    check("flush hazard cnt",   32'(bubble_cnt), 32'd3);
    check("flush hazard valid", 32'(valid_o), 32'd0);

    // Other immediate classes
    drive(SW, 32'h0, 32'h0);
    tick();
    check("sw imm",       Immediate, 32'hFFFFFFFC);
    check("sw mem_write", 32'(mem_write_o), 32'd1);
    check("sw reg_write", 32'(reg_write_o), 32'd0);
    drive(BEQ, 32'h0, 32'h0);
    tick();
    check("beq imm",       Immediate, 32'hFFFFFFFC);
    check("beq mem_write", 32'(mem_write_o), 32'd0);
    drive(LUI, 32'h0, 32'h0);
    tick();
    check("lui imm",       Immediate, 32'h12345000);
    check("lui reg_write", 32'(reg_write_o), 32'd1);
    drive(JAL, 32'h0, 32'h0);
    tick();
    check("jal imm",       Immediate, 32'h8);
    check("jal reg_write", 32'(reg_write_o), 32'd0);
    in_valid = 1'b0;
    drive(ADDI, 32'h0, 32'h0);
    tick();
    check("invalid valid",     32'(valid_o), 32'd0);
    check("invalid reg_write", 32'(reg_write_o), 32'd0);
    in_valid = 1'b1;

    // Saturation: start the counter just below its ceiling
    force dut.bubble_cnt_q = 16'hFFFD;
    tick();
    release dut.bubble_cnt_q;
    #1;
    exp_cnt = 16'hFFFD;
    check("preload cnt", 32'(bubble_cnt), 32'(exp_cnt));
    for (int i = 0; i < 3; i++) begin
      drive(LW5, 32'h0, 32'h0);
      tick();
      drive(SLTI, 32'h0, 32'h0);
      tick();
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      check("saturating cnt", 32'(bubble_cnt), 32'(exp_cnt));
    end

    // Reset in the middle of a stalled hazard
    drive(LW5, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    drive(SLTI, 32'h0, 32'h0);
    check("pre-reset hazard", 32'(load_use_stall), 32'd1);
    reset = 1'b1;
    tick();
    check_zero("mid-hazard reset");
    reset = 1'b0;
    stall = 1'b0;
    tick();
    check("after reset valid", 32'(valid_o), 32'd1);
    check("after reset rd",    32'(rd_o), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RISC-V pipeline. It captures the instruction from ID together with the register-file read data, generates the sign-extended immediate, and registers the operands (`SrcA`, `SrcB`, `Immediate`) and control fields consumed by the EX-stage ALU operations (`slti_operation` and siblings). It detects load-use hazards against the instruction currently in EX, inserts bubbles, and honours external stall and flush.

## Interface
- `DATA_WIDTH`, default 32: operand and immediate width; only 32 is supported.
- `OPCODE_LENGTH`, default 4: width of `alu_ctrl_o`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: the ID instruction is valid.
- `instr` input 32: raw instruction from IF/ID.
- `rs1_data` input DATA_WIDTH: register-file read port 1.
- `rs2_data` input DATA_WIDTH: register-file read port 2.
- `stall` input 1: hold the stage contents (downstream backpressure).
- `flush` input 1: kill the stage contents (branch or jump redirect).
- `load_use_stall` output 1: combinational; tells IF/ID and PC to hold.
- `valid_o` output 1: EX contents are valid.
- `SrcA` output DATA_WIDTH: registered `rs1_data`.
- `SrcB` output DATA_WIDTH: registered `rs2_data`.
- `Immediate` output DATA_WIDTH: registered sign-extended immediate.
- `rd_o` output 5: destination register.
- `funct3_o` output 3: instr[14:12].
- `alu_ctrl_o` output OPCODE_LENGTH: {instr[30], funct3} for R-type and for I-type shifts; {0, funct3} for other I-type ALU instructions; 0 otherwise.
- `alu_src_o` output 1: ALU operand B is `Immediate`.
- `reg_write_o` output 1: write-back enable.
- `mem_read_o` output 1: load in EX.
- `mem_write_o` output 1: store in EX.
- `bubble_cnt` output 16: saturating count of inserted load-use bubbles.

## Operation
- **Immediate generation** (combinational, from `instr`):
  - I-type (opcodes 0010011, 0000011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R-type and unknown opcodes: 0.
- **Register-use decode**:
  - rs1 is used by every class except U and J.
  - rs2 is used by R, S and B.
  - Unknown opcodes: `reg_write`, `mem_read` and `mem_write` are all 0.
- **Hazard**: `load_use_stall` = `in_valid & valid_o & mem_read_o & (rd_o != 0) & ((uses_rs1 & rd_o == instr[19:15]) | (uses_rs2 & rd_o == instr[24:20]))`.
- **Next-state priority**, evaluated on each rising edge:
  1. `reset`: every output register is cleared to 0.
  2. `flush`: bubble. `valid_o`, `reg_write_o`, `mem_read_o` and `mem_write_o` are 0; data fields are 0.
  3. `stall`: all registers hold; `bubble_cnt` holds.
  4. `load_use_stall`: bubble as in step 2; `bubble_cnt` increments, saturating at 0xFFFF.
  5. Otherwise: load the decoded fields. `valid_o` = `in_valid`; control bits are ANDed with `in_valid`.
- `flush` overrides a coincident `load_use_stall`; `bubble_cnt` does not count it.
- `stall` with a pending hazard holds the load in EX; the hazard stays asserted.
- Writes to rd = x0 have `reg_write_o` forced to 0. This also prevents false hazards.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- `load_use_stall` is purely combinational from the inputs and the current registers. Its first-edge bubble comes from step 4.
- Load-use costs exactly 1 bubble per occurrence. The cycle after the bubble, `valid_o`/`mem_read_o` describe the bubble, so the hazard drops and the dependent instruction loads on the next edge.
- A reset asserted mid-stall or mid-hazard clears everything on that edge. The first instruction loads on the first edge with `reset` low.
- Reset values: all outputs are 0, including `bubble_cnt`. `load_use_stall` is 0 because `valid_o` is 0.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid` = 1 and arbitrary inputs -> every output is 0 and `load_use_stall` = 0.
- I-type capture: `instr` = 0xFFB00293 (addi x5,x0,-5), `rs1_data` = 0 -> after 1 edge: `Immediate` = 0xFFFFFFFB, `rd_o` = 5, `alu_src_o` = 1, `reg_write_o` = 1, `valid_o` = 1. Then `instr` = 0x0032A313 (slti x6,x5,3), `rs1_data` = 0xFFFFFFFB -> `SrcA` = 0xFFFFFFFB, `Immediate` = 3, `funct3_o` = 2, `alu_ctrl_o` = 2.
- Load-use: 0x0000A283 (lw x5,0(x1)), then 0x0032A313 -> `load_use_stall` = 1 for exactly 1 cycle; EX shows a bubble; the next edge loads the slti; `bubble_cnt` = 1. Repeat with slti rs1 = x6 -> no stall.
- Stall/flush priority: assert `stall` and `flush` together -> bubble. `stall` alone for 3 cycles -> outputs unchanged.
- Immediates for other classes: S 0xFE112E23 (sw x1,-4(x2)) -> `Immediate` 0xFFFFFFFC, `mem_write_o` = 1. B 0xFE000EE3 (beq x0,x0,-4) -> 0xFFFFFFFC. U 0x123452B7 (lui x5) -> 0x12345000. J 0x0080006F (jal x0,8) -> 8 and `reg_write_o` = 0.
- Saturation: force 0x10000 load-use hazards -> `bubble_cnt` stays at 0xFFFF.
